// File: rtl/led_mode_sequencer.sv
// -----------------------------------------------------------------------------
// led_mode_sequencer
//
// Top-level LED controller for the 12 MHz board. Steps the four red LEDs
// through COUNT / SCAN / BLINK / OFF display modes using an internal tick
// prescaler. A debounced push-button advances the mode. GLED5 is a
// power/run indicator that goes high on the first edge after reset.
//
// Ports:
//   CLK_IN  - 12 MHz system clock, all logic on its rising edge
//   RST_IN  - synchronous reset, active-high
//   BTN_IN  - raw asynchronous push-button, high = pressed
//   RLED1   - red LED 1 (pattern MSB)
//   RLED2   - red LED 2
//   RLED3   - red LED 3
//   RLED4   - red LED 4 (pattern LSB)
//   GLED5   - green run indicator
//
// Optional build macro:
//   LED_PWM_EN - when defined, a free-running PWM_BITS counter dims the red
//                LEDs: each red output is its pattern bit AND
//                (pwm_cnt < BRIGHTNESS). GLED5 is never dimmed.
// -----------------------------------------------------------------------------
module led_mode_sequencer #(
   parameter int TICK_DIV        = 1200000,
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int PWM_BITS        = 4,
   parameter int BRIGHTNESS      = 8
) (
   input  logic CLK_IN,
   input  logic RST_IN,
   input  logic BTN_IN,
   output logic RLED1,
   output logic RLED2,
   output logic RLED3,
   output logic RLED4,
   output logic GLED5
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DEB_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      MODE_COUNT = 2'd0,
      MODE_SCAN  = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_OFF   = 2'd3
   } mode_t;

   // State registers
   mode_t            mode_reg,      mode_next;
   logic [3:0]       step_reg,      step_next;
   logic [PRE_W-1:0] pre_reg,       pre_next;
   logic [1:0]       pos_reg,       pos_next;
   logic             dir_up_reg,    dir_up_next;
   logic             phase_reg,     phase_next;
   logic             sync1_reg,     sync2_reg;
   logic             deb_level_reg, deb_level_next;
   logic [DEB_W-1:0] deb_cnt_reg,   deb_cnt_next;
   logic [3:0]       led_reg,       led_next;
   logic             gled_reg;

   logic             tick;
   logic             adv;
   logic [3:0]       pattern_next;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // Debouncer: any cycle where the synced level matches the accepted
      // level restarts the stability count.
      deb_level_next = deb_level_reg;
      deb_cnt_next   = deb_cnt_reg;
      adv            = 1'b0;
      if (sync2_reg == deb_level_reg) begin
         deb_cnt_next = '0;
      end else if (deb_cnt_reg == DEB_LAST) begin
         deb_level_next = sync2_reg;
         deb_cnt_next   = '0;
         // Only a press is a command; a release is silently accepted.
         adv            = sync2_reg;
      end else begin
         deb_cnt_next = deb_cnt_reg + 1'b1;
      end

      tick     = (pre_reg == PRE_LAST);
      pre_next = tick ? '0 : pre_reg + 1'b1;

      mode_next   = mode_reg;
      step_next   = step_reg;
      pos_next    = pos_reg;
      dir_up_next = dir_up_reg;
      phase_next  = phase_reg;

      if (adv) begin
         // Mode change restarts the pattern from a clean origin; any tick in
         // the same cycle is dropped.
         unique case (mode_reg)
            MODE_COUNT: mode_next = MODE_SCAN;
            MODE_SCAN:  mode_next = MODE_BLINK;
            MODE_BLINK: mode_next = MODE_OFF;
            default:    mode_next = MODE_COUNT;
         endcase
         step_next   = 4'd0;
         pre_next    = '0;
         pos_next    = 2'd0;
         dir_up_next = 1'b1;
         phase_next  = 1'b1;
      end else if (tick) begin
         unique case (mode_reg)
            MODE_COUNT: step_next = step_reg + 4'd1;
            MODE_SCAN: begin
               // Bounce so that each end position is shown only once.
               if (dir_up_reg) begin
                  if (pos_reg == 2'd3) begin
                     pos_next    = 2'd2;
                     dir_up_next = 1'b0;
                  end else begin
                     pos_next = pos_reg + 2'd1;
                  end
               end else begin
                  if (pos_reg == 2'd0) begin
                     pos_next    = 2'd1;
                     dir_up_next = 1'b1;
                  end else begin
                     pos_next = pos_reg - 2'd1;
                  end
               end
            end
            MODE_BLINK: phase_next = ~phase_reg;
            default: ;
         endcase
      end

      // Pattern is built from next-state so the LEDs change on the same
      // edge as the state they display.
      unique case (mode_next)
         MODE_COUNT: pattern_next = step_next;
         MODE_SCAN:  pattern_next = 4'b1000 >> pos_next;
         MODE_BLINK: pattern_next = {4{phase_next}};
         default:    pattern_next = 4'b0000;
      endcase
   end

`ifdef LED_PWM_EN
   localparam logic [PWM_BITS:0] BRIGHT_CMP = (PWM_BITS + 1)'(BRIGHTNESS);

   logic [PWM_BITS-1:0] pwm_cnt_reg;
   logic [PWM_BITS-1:0] pwm_cnt_next;

   assign pwm_cnt_next = pwm_cnt_reg + 1'b1;
   // Gate against the counter value that will be live alongside the output.
   assign led_next     = pattern_next & {4{({1'b0, pwm_cnt_next} < BRIGHT_CMP)}};

   always_ff @(posedge CLK_IN) begin
      if (RST_IN) begin
         pwm_cnt_reg <= '0;
      end else begin
         pwm_cnt_reg <= pwm_cnt_next;
      end
   end
`else
   assign led_next = pattern_next;

   // PWM parameters only matter with the dimming gate built in.
   if ((PWM_BITS < 1) || (BRIGHTNESS < 0)) begin : g_pwm_params_ignored
   end
`endif

   // -------------------------------------------------------------------------
   // State and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK_IN) begin
      if (RST_IN) begin
         mode_reg      <= MODE_COUNT;
         step_reg      <= 4'd0;
         pre_reg       <= '0;
         pos_reg       <= 2'd0;
         dir_up_reg    <= 1'b1;
         phase_reg     <= 1'b0;
         sync1_reg     <= 1'b0;
         sync2_reg     <= 1'b0;
         deb_level_reg <= 1'b0;
         deb_cnt_reg   <= '0;
         led_reg       <= 4'b0000;
         gled_reg      <= 1'b0;
      end else begin
         mode_reg      <= mode_next;
         step_reg      <= step_next;
         pre_reg       <= pre_next;
         pos_reg       <= pos_next;
         dir_up_reg    <= dir_up_next;
         phase_reg     <= phase_next;
         sync1_reg     <= BTN_IN;
         sync2_reg     <= sync1_reg;
         deb_level_reg <= deb_level_next;
         deb_cnt_reg   <= deb_cnt_next;
         led_reg       <= led_next;
         gled_reg      <= 1'b1;
      end
   end

   assign RLED1 = led_reg[3];
   assign RLED2 = led_reg[2];
   assign RLED3 = led_reg[1];
   assign RLED4 = led_reg[0];
   assign GLED5 = gled_reg;

endmodule

// File: doc/led_mode_sequencer.md
Name: led_mode_sequencer

Overview:
- Owns RLED1..RLED4 and GLED5 on the 12 MHz board.
- Sequences the four red LEDs through a fixed set of display modes, stepped by an internal tick prescaler.
- A debounced push-button input advances the mode.
- Replaces the free-running-counter LED hookup as the top-level LED controller.

Parameters:
TICK_DIV, 1200000, clock cycles per pattern step (10 Hz at 12 MHz); legal range >= 2
DEBOUNCE_CYCLES, 120000, consecutive stable cycles required to accept a button level change; legal range >= 1
PWM_BITS, 4, width of PWM counter (used only with LED_PWM_EN)
BRIGHTNESS, 8, PWM on-count out of 2^PWM_BITS (used only with LED_PWM_EN)

Ports:
CLK_IN  input  1  12 MHz system clock; all logic on its rising edge
RST_IN  input  1  synchronous reset, active-high
BTN_IN  input  1  raw asynchronous push-button, high = pressed
RLED1  output  1  red LED 1; MSB position of pattern
RLED2  output  1  red LED 2
RLED3  output  1  red LED 3
RLED4  output  1  red LED 4; LSB position of pattern
GLED5  output  1  green LED; power/run indicator

Behaviour:
- Reset (RST_IN high at a clock edge):
  - mode=COUNT, step=0, prescaler=0, scan position=0, scan direction=up.
  - Both button synchronizer flops and the debounced level = 0; debounce counter = 0.
  - All five outputs 0.
  - Reset asserted mid-operation overrides everything on the same edge.
- Outputs are registered from state with 1-cycle latency. GLED5 goes to 1 on the first edge after RST_IN deasserts and stays 1.
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - tick is an internal 1-cycle strobe asserted while prescaler==TICK_DIV-1.
- Button path:
  - 2-flop synchronizer (2 cycles latency) feeds the debouncer.
  - Debounce counter clears whenever the synced level equals the debounced level.
  - Otherwise it increments; at DEBOUNCE_CYCLES-1 the debounced level takes the synced level and the counter clears.
  - A debounced 0->1 transition produces a 1-cycle adv strobe. Release produces no action.
- Mode FSM: COUNT -> SCAN -> BLINK -> OFF -> COUNT, advancing on adv.
  - On adv: mode advances; step, prescaler and scan position are cleared; scan direction is set to up.
  - The entry pattern is visible on the cycle after adv.
- Simultaneous adv and tick: adv wins; the tick is discarded (no step update).
- Patterns, with {RLED1,RLED2,RLED3,RLED4} shown MSB first:
  - COUNT: LEDs = 4-bit step; step increments on tick and wraps 15->0.
  - SCAN: exactly one LED lit at position p (0=RLED1..3=RLED4).
    - p moves one place per tick, reversing at the ends: 0,1,2,3,2,1,0,1,...
    - The end positions are shown once per bounce.
  - BLINK: all four LEDs equal to a phase bit. Phase = 1 on entry and toggles on each tick.
  - OFF: all four LEDs 0; the prescaler keeps running but has no effect.
- Widths:
  - Prescaler width = clog2(TICK_DIV).
  - Debounce counter width = clog2(DEBOUNCE_CYCLES+1).
  - step is 4 bits; scan position is 2 bits; the direction flag is 1 bit.

Optional Feature:
LED_PWM_EN
- Defined:
  - A free-running PWM_BITS counter (cleared by reset) gates the four red LEDs.
  - Each red output = pattern bit AND (pwm_cnt < BRIGHTNESS).
  - With the gate, the red-LED output latency is still 1 cycle.
  - GLED5 is not gated.
- Undefined: there is no PWM counter; red outputs equal pattern bits directly.

Test Plan:
All scenarios use TICK_DIV=4 and DEBOUNCE_CYCLES=3.
- Reset: hold RST_IN 3 cycles with BTN_IN=1 -> all outputs 0 during reset. First cycle after release: GLED5=1, reds=0000; no mode advance until the button has been debounced from 0.
- COUNT: run 64 cycles -> reds step 0000,0001,...,1111,0000, changing every 4 cycles, with each change 1 cycle after its tick.
- Debounce:
  - BTN_IN high 2 cycles, then low -> no mode change.
  - BTN_IN high 10 cycles -> mode SCAN, reds=1000. Ticks then give 0100,0010,0001,0010,0100,1000.
  - Release -> no change.
- Mode wrap: three further presses -> BLINK 1111 toggling to 0000 every 4 cycles; then OFF 0000 held for 40 cycles; then COUNT 0000 restarting at step 0.
- Corners:
  - adv coincident with tick in COUNT at step 5 -> SCAN entry 1000, no COUNT step 6 shown.
  - RST_IN pulsed for 1 cycle mid-SCAN -> reds 0000, then COUNT from 0000.
- LED_PWM_EN (PWM_BITS=4, BRIGHTNESS=4), in BLINK on-phase -> each red LED high exactly 4 of every 16 cycles; GLED5 constant 1.
